vec_add_seq: RTL and testbench



---
 rtl/vseq_pkg.sv | 20 ++
 rtl/vlane_add.sv | 28 ++
 rtl/vec_add_seq.sv | 118 +++++++++++
 tb/tb_vec_add_seq.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/vseq_pkg.sv
// Shared definitions for the packed-vector add sequencer: FSM states,
// default geometry and the lane-index width helper.
// Optional build macro VSEQ_SAT_EN (saturating lanes) is handled in vlane_add.
package vseq_pkg;

  localparam int unsigned LANES_DEF = 4;
  localparam int unsigned W_DEF     = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } vseq_state_e;

  // Width of the lane index; at least one bit so the register always exists.
  function automatic int unsigned idx_width(input int unsigned lanes);
    return (lanes > 1) ? $clog2(lanes) : 1;
  endfunction

endpackage

// File: rtl/vlane_add.sv
// Shared W-bit lane adder with carry-out.
// Build macro VSEQ_SAT_EN: when defined, a carrying lane saturates to all-ones;
// otherwise the lane wraps modulo 2^W. The carry is reported raw in both builds.
module vlane_add
  import vseq_pkg::*;
#(
  parameter int unsigned W = W_DEF
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum_c,
  output logic         carry_c
);

  logic [W:0] full_c;

  // (W+1)-bit unsigned add, then optional saturation of the lane result
  always_comb begin
    full_c  = {1'b0, a} + {1'b0, b};
    carry_c = full_c[W];
`ifdef VSEQ_SAT_EN
    sum_c   = full_c[W] ? {W{1'b1}} : full_c[W-1:0];
`else
    sum_c   = full_c[W-1:0];
`endif
  end

endmodule

// File: rtl/vec_add_seq.sv
// Packed-vector add sequencer: latches two LANES x W operand vectors and
// walks one shared lane adder across them, lane 0 first, then pulses done.
// Build macro VSEQ_SAT_EN selects saturating lanes inside vlane_add; this
// module is identical in both builds.
module vec_add_seq
  import vseq_pkg::*;
#(
  parameter int unsigned LANES = LANES_DEF,
  parameter int unsigned W     = W_DEF
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [LANES*W-1:0] va,
  input  logic [LANES*W-1:0] vb,
  output logic               ready,
  output logic               busy,
  output logic               done,
  output logic [LANES*W-1:0] vout,
  output logic [LANES-1:0]   ovf
);

  localparam int unsigned   IW       = idx_width(LANES);
  localparam logic [IW-1:0] LAST_IDX = IW'(LANES - 1);

  vseq_state_e        state_q;
  vseq_state_e        state_d;
  logic [IW-1:0]      idx_q;
  logic [LANES*W-1:0] a_q;
  logic [LANES*W-1:0] b_q;
  logic [W-1:0]       lane_a_c;
  logic [W-1:0]       lane_b_c;
  logic [W-1:0]       lane_sum_c;
  logic               lane_carry_c;

  // Select the current lane of each latched operand
  always_comb begin
    lane_a_c = '0;
    lane_b_c = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      if (idx_q == IW'(i)) begin
        lane_a_c = a_q[i*W +: W];
        lane_b_c = b_q[i*W +: W];
      end
    end
  end

  vlane_add #(.W(W)) u_lane (
    .a       (lane_a_c),
    .b       (lane_b_c),
    .sum_c   (lane_sum_c),
    .carry_c (lane_carry_c)
  );

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; start is only honoured in IDLE, so it is never queued
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (idx_q == LAST_IDX) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Status flags registered from the next state so they track the state register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ready <= 1'b1;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      ready <= (state_d == IDLE);
      busy  <= (state_d != IDLE);
      done  <= (state_d == DONE);
    end
  end

  // Operand latch, lane index and result assembly
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      a_q   <= '0;
      b_q   <= '0;
      idx_q <= '0;
      vout  <= '0;
      ovf   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            a_q   <= va;
            b_q   <= vb;
            idx_q <= '0;
            vout  <= '0;
            ovf   <= '0;
          end
        end
        RUN: begin
          for (int unsigned i = 0; i < LANES; i++) begin
            if (idx_q == IW'(i)) begin
              vout[i*W +: W] <= lane_sum_c;
              ovf[i]         <= lane_carry_c;
            end
          end
          if (idx_q != LAST_IDX) idx_q <= idx_q + IW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_vec_add_seq.sv
// Self-checking bench for vec_add_seq with a result scoreboard.
// Honours VSEQ_SAT_EN in its reference model to match the build under test.
module tb_vec_add_seq;

  localparam int unsigned LANES = 4;
  localparam int unsigned W     = 8;
  localparam int unsigned VW    = LANES * W;

  typedef struct {
    logic [VW-1:0]    v;
    logic [LANES-1:0] o;
  } exp_t;

  logic             clock;
  logic             reset;
  logic             start;
  logic [VW-1:0]    va;
  logic [VW-1:0]    vb;
  logic             ready;
  logic             busy;
  logic             done;
  logic [VW-1:0]    vout;
  logic [LANES-1:0] ovf;

  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;
  int   done_cnt = 0;
  int   lat;
  int   base;
  exp_t exp_q[$];
  int   done_cyc_q[$];

  vec_add_seq #(.LANES(LANES), .W(W)) dut (
    .clock (clock),
    .reset (reset),
    .start (start),
    .va    (va),
    .vb    (vb),
    .ready (ready),
    .busy  (busy),
    .done  (done),
    .vout  (vout),
    .ovf   (ovf)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc++;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  function automatic exp_t model(input logic [VW-1:0] a, input logic [VW-1:0] b);
    exp_t       r;
    logic [W:0] s;
    for (int i = 0; i < LANES; i++) begin
      s = {1'b0, a[i*W +: W]} + {1'b0, b[i*W +: W]};
      r.o[i] = s[W];
`ifdef VSEQ_SAT_EN
      r.v[i*W +: W] = s[W] ? {W{1'b1}} : s[W-1:0];
`else
      r.v[i*W +: W] = s[W-1:0];
`endif
    end
    return r;
  endfunction

  // Scoreboard: every done pulse pops and compares one expected result
  always @(negedge clock) begin
    exp_t e;
    if (!reset && done) begin
      done_cnt++;
      done_cyc_q.push_back(cyc);
      if (exp_q.size() == 0) begin
        check("unexpected_done", 64'd1, 64'd0);
      end else begin
        e = exp_q.pop_front();
        check("sb_vout", 64'(vout), 64'(e.v));
        check("sb_ovf", 64'(ovf), 64'(e.o));
      end
    end
  end

  // Returns at a falling edge where ready is high; times out as a failure
  task automatic wait_ready();
    for (int k = 0; k < 20; k++) begin
      @(negedge clock);
      if (ready) return;
    end
    check("ready_timeout", 64'd0, 64'd1);
  endtask

  // One pulsed-start operation; returns cycles from accept edge to done
  task automatic run_op(input logic [VW-1:0] a, input logic [VW-1:0] b, output int latency);
    int acc;
    wait_ready();
    va = a; vb = b; start = 1'b1;
    exp_q.push_back(model(a, b));
    @(posedge clock);
    #1;
    acc   = cyc;
    start = 1'b0;
    latency = -1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clock);
      if (done) begin
        latency = cyc - acc;
        break;
      end
    end
    if (latency < 0) check("done_timeout", 64'd0, 64'd1);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; va = '0; vb = '0;
    repeat (3) @(negedge clock);
    check("rst_ready", 64'(ready), 64'd1);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_vout", 64'(vout), 64'd0);
    check("rst_ovf", 64'(ovf), 64'd0);
    reset = 1'b0;

    // Basic add with latency, single-cycle done and status checks
    run_op(32'h04030201, 32'h10203040, lat);
    check("basic_latency", 64'(lat), 64'd4);
    check("basic_vout", 64'(vout), 64'h14233241);
    check("basic_ovf", 64'(ovf), 64'h0);
    check("done_busy", 64'(busy), 64'd1);
    check("done_ready", 64'(ready), 64'd0);
    @(negedge clock);
    check("done_width", 64'(done), 64'd0);
    check("ready_back", 64'(ready), 64'd1);
    check("busy_clear", 64'(busy), 64'd0);
    repeat (2) @(negedge clock);
    check("vout_held", 64'(vout), 64'h14233241);

    // Overflow lanes 0 and 3
    run_op(32'h800000FF, 32'h80000002, lat);
    check("ovf_latency", 64'(lat), 64'd4);
    check("ovf_flags", 64'(ovf), 64'h9);
`ifdef VSEQ_SAT_EN
    check("ovf_vout", 64'(vout), 64'hFF0000FF);
`else
    check("ovf_vout", 64'(vout), 64'h00000001);
`endif

    // Start during RUN with different operands is ignored
    wait_ready();
    base = done_cnt;
    va = 32'h11223344; vb = 32'h01010101; start = 1'b1;
    exp_q.push_back(model(32'h11223344, 32'h01010101));
    @(posedge clock); #1 start = 1'b0;
    check("run_ready", 64'(ready), 64'd0);
    @(posedge clock); #1;
    va = 32'hDEADBEEF; vb = 32'hCAFEF00D; start = 1'b1;
    @(posedge clock); #1 start = 1'b0;
    repeat (12) @(negedge clock);
    check("ignored_one_done", 64'(done_cnt - base), 64'd1);
    check("ignored_vout", 64'(vout), 64'h12233445);

    // Asynchronous reset two cycles after accept aborts the operation
    wait_ready();
    base = done_cnt;
    va = 32'hFFFFFFFF; vb = 32'h01010101; start = 1'b1;
    exp_q.push_back(model(32'hFFFFFFFF, 32'h01010101));
    @(posedge clock); #1 start = 1'b0;
    @(posedge clock);
    @(posedge clock);
    #3 reset = 1'b1;
    #1;
    check("abort_vout", 64'(vout), 64'd0);
    check("abort_ovf", 64'(ovf), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    check("abort_ready", 64'(ready), 64'd1);
    check("abort_busy", 64'(busy), 64'd0);
    void'(exp_q.pop_back());
    @(negedge clock);
    reset = 1'b0;
    repeat (8) @(negedge clock);
    check("abort_no_done", 64'(done_cnt - base), 64'd0);
    run_op(32'h7F7F7F7F, 32'h01800081, lat);
    check("post_abort_latency", 64'(lat), 64'd4);

    // Back-to-back with start held high and operands changing per op
    repeat (2) @(negedge clock);
    done_cyc_q.delete();
    for (int n = 0; n < 5; n++) begin
      logic [VW-1:0] a;
      logic [VW-1:0] b;
      wait_ready();
      a = VW'($urandom); b = VW'($urandom);
      va = a; vb = b; start = 1'b1;
      exp_q.push_back(model(a, b));
      @(posedge clock);
    end
    #1 start = 1'b0;
    for (int k = 0; k < 40 && exp_q.size() != 0; k++) @(negedge clock);
    check("b2b_drained", 64'(exp_q.size()), 64'd0);
    check("b2b_count", 64'(done_cyc_q.size()), 64'd5);
    for (int i = 1; i < done_cyc_q.size(); i++)
      check("b2b_spacing", 64'(done_cyc_q[i] - done_cyc_q[i-1]), 64'd6);

    repeat (3) @(negedge clock);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
